arp_req_arbiter: RTL and testbench

- Shares the single ARP lookup port of the `arp` block (arp_request_* / arp_response_*) among PORTS independent requesters, such as IP TX paths or UDP channels.
- Grants one lookup at a time in round-robin order and forwards the ARP block's response back to the requester that issued it.
- Sits between the per-channel IP senders and the `arp` instance, in the same clk domain.

---
 rtl/arp_req_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_arp_req_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_req_arbiter.sv
// Round-robin arbiter sharing one ARP lookup port among PORTS requesters.
// Define ARP_REQ_TIMEOUT_EN to add the response watchdog and late-response discard.
module arp_req_arbiter #(
  parameter int unsigned PORTS          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORTS-1:0]      s_req_valid,
  output logic [PORTS-1:0]      s_req_ready,
  input  logic [PORTS*32-1:0]   s_req_ip,
  output logic [PORTS-1:0]      s_resp_valid,
  input  logic [PORTS-1:0]      s_resp_ready,
  output logic                  s_resp_error,
  output logic [47:0]           s_resp_mac,
  output logic                  m_arp_request_valid,
  input  logic                  m_arp_request_ready,
  output logic [31:0]           m_arp_request_ip,
  input  logic                  m_arp_response_valid,
  output logic                  m_arp_response_ready,
  input  logic                  m_arp_response_error,
  input  logic [47:0]           m_arp_response_mac,
  output logic                  busy
);

  localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [PW-1:0]    rr_ptr, rr_ptr_nxt, grant, grant_nxt;
  logic [PORTS-1:0] s_req_ready_nxt, s_resp_valid_nxt;
  logic             s_resp_error_nxt, req_valid_nxt, rsp_ready_nxt, busy_nxt;
  logic [47:0]      s_resp_mac_nxt;
  logic [31:0]      req_ip_nxt;
  logic [31:0]      ip_arr [PORTS];
  logic             pick_found, grant_ok, rsp_fire, deliver;
  logic [PW-1:0]    pick_idx, cand;

  for (genvar i = 0; i < int'(PORTS); i++) begin : g_ip
    assign ip_arr[i] = s_req_ip[32*i +: 32];
  end

  assign rsp_fire = m_arp_response_valid & m_arp_response_ready;

`ifdef ARP_REQ_TIMEOUT_EN
  logic [31:0] wait_cnt, wait_cnt_nxt;
  logic [1:0]  stale, stale_nxt;
  logic        stale_inc, stale_dec;

  assign grant_ok  = (stale != 2'd3);
  // With stale responses outstanding, the next accepted response is a late one.
  assign stale_dec = rsp_fire & (stale != 2'd0);
  assign deliver   = rsp_fire & (stale == 2'd0);
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(TIMEOUT_CYCLES);
  assign grant_ok   = 1'b1;
  assign deliver    = rsp_fire;
`endif

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < int'(PORTS); i++) begin
      cand = PW'((int'(rr_ptr) + i) % int'(PORTS));
      if (!pick_found && s_req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state;
    rr_ptr_nxt       = rr_ptr;
    grant_nxt        = grant;
    s_req_ready_nxt  = '0;
    s_resp_valid_nxt = s_resp_valid;
    s_resp_error_nxt = s_resp_error;
    s_resp_mac_nxt   = s_resp_mac;
    req_valid_nxt    = m_arp_request_valid;
    req_ip_nxt       = m_arp_request_ip;
`ifdef ARP_REQ_TIMEOUT_EN
    wait_cnt_nxt     = wait_cnt;
    stale_inc        = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_found && grant_ok) begin
          grant_nxt       = pick_idx;
          s_req_ready_nxt = PORTS'(1) << pick_idx;
          req_valid_nxt   = 1'b1;
          req_ip_nxt      = ip_arr[pick_idx];
          rr_ptr_nxt      = (pick_idx == PW'(PORTS - 1)) ? '0 : pick_idx + PW'(1);
          state_nxt       = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_arp_request_valid && m_arp_request_ready) begin
          req_valid_nxt = 1'b0;
          state_nxt     = ST_WAIT;
`ifdef ARP_REQ_TIMEOUT_EN
          wait_cnt_nxt  = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (deliver) begin
          s_resp_valid_nxt = PORTS'(1) << grant;
          s_resp_error_nxt = m_arp_response_error;
          s_resp_mac_nxt   = m_arp_response_mac;
          state_nxt        = ST_RESP;
        end
`ifdef ARP_REQ_TIMEOUT_EN
        else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          s_resp_valid_nxt = PORTS'(1) << grant;
          s_resp_error_nxt = 1'b1;
          s_resp_mac_nxt   = '0;
          stale_inc        = 1'b1;
          state_nxt        = ST_RESP;
        end else begin
          wait_cnt_nxt = wait_cnt + 32'd1;
        end
`endif
      end
      ST_RESP: begin
        if (s_resp_ready[grant]) begin
          s_resp_valid_nxt = '0;
          s_resp_error_nxt = 1'b0;
          s_resp_mac_nxt   = '0;
          state_nxt        = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
`ifdef ARP_REQ_TIMEOUT_EN
    case ({stale_inc, stale_dec})
      2'b10:   stale_nxt = stale + 2'd1;
      2'b01:   stale_nxt = stale - 2'd1;
      default: stale_nxt = stale;
    endcase
    rsp_ready_nxt = (state_nxt == ST_WAIT) ||
                    ((stale_nxt != 2'd0) && (state_nxt != ST_REQ));
`else
    rsp_ready_nxt = (state_nxt == ST_WAIT);
`endif
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ST_IDLE;
      rr_ptr               <= '0;
      grant                <= '0;
      s_req_ready          <= '0;
      s_resp_valid         <= '0;
      s_resp_error         <= 1'b0;
      s_resp_mac           <= '0;
      m_arp_request_valid  <= 1'b0;
      m_arp_request_ip     <= '0;
      m_arp_response_ready <= 1'b0;
      busy                 <= 1'b0;
`ifdef ARP_REQ_TIMEOUT_EN
      wait_cnt             <= '0;
      stale                <= '0;
`endif
    end else begin
      state                <= state_nxt;
      rr_ptr               <= rr_ptr_nxt;
      grant                <= grant_nxt;
      s_req_ready          <= s_req_ready_nxt;
      s_resp_valid         <= s_resp_valid_nxt;
      s_resp_error         <= s_resp_error_nxt;
      s_resp_mac           <= s_resp_mac_nxt;
      m_arp_request_valid  <= req_valid_nxt;
      m_arp_request_ip     <= req_ip_nxt;
      m_arp_response_ready <= rsp_ready_nxt;
      busy                 <= busy_nxt;
`ifdef ARP_REQ_TIMEOUT_EN
      wait_cnt             <= wait_cnt_nxt;
      stale                <= stale_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_arp_req_arbiter.sv
// Bench for arp_req_arbiter: directed vector table, random transactions against a
// round-robin reference, reset-in-WAIT, and the ARP_REQ_TIMEOUT_EN watchdog when defined.
module tb_arp_req_arbiter;

  localparam int NP = 4;

  logic              clk, rst;
  logic [NP-1:0]     s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
  logic [NP*32-1:0]  s_req_ip;
  logic              s_resp_error;
  logic [47:0]       s_resp_mac;
  logic              m_arp_request_valid, m_arp_request_ready;
  logic [31:0]       m_arp_request_ip;
  logic              m_arp_response_valid, m_arp_response_ready, m_arp_response_error;
  logic [47:0]       m_arp_response_mac;
  logic              busy;

  int n_checks = 0;
  int n_err    = 0;
  int model_rr = 0;

`ifdef ARP_REQ_TIMEOUT_EN
  arp_req_arbiter #(.PORTS(NP), .TIMEOUT_CYCLES(16)) dut (
`else
  arp_req_arbiter #(.PORTS(NP)) dut (
`endif
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_ip(s_req_ip),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .s_resp_error(s_resp_error), .s_resp_mac(s_resp_mac),
    .m_arp_request_valid(m_arp_request_valid), .m_arp_request_ready(m_arp_request_ready),
    .m_arp_request_ip(m_arp_request_ip),
    .m_arp_response_valid(m_arp_response_valid), .m_arp_response_ready(m_arp_response_ready),
    .m_arp_response_error(m_arp_response_error), .m_arp_response_mac(m_arp_response_mac),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] mask;
    logic [31:0]   base;
    int            req_lat;
    int            rsp_lat;
    int            acc_lat;
    logic          err;
    logic [47:0]   mac;
    int            exp_g;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requesting port at or after the pointer, modulo NP.
  function automatic int model_pick(input logic [NP-1:0] mask);
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (model_rr + i) % NP;
      if (((mask >> p) & NP'(1)) != '0) return p;
    end
    return 0;
  endfunction

  task automatic set_ips(input logic [31:0] base);
    for (int p = 0; p < NP; p++) s_req_ip[p*32 +: 32] = base ^ 32'(p);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, 64'(s_req_ready), 64'(0));
    chk({tag, "_resp_valid"}, 64'(s_resp_valid), 64'(0));
    chk({tag, "_resp_error"}, 64'(s_resp_error), 64'(0));
    chk({tag, "_resp_mac"}, 64'(s_resp_mac), 64'(0));
    chk({tag, "_m_req_valid"}, 64'(m_arp_request_valid), 64'(0));
    chk({tag, "_m_req_ip"}, 64'(m_arp_request_ip), 64'(0));
    chk({tag, "_m_rsp_ready"}, 64'(m_arp_response_ready), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic wait_grant(output int waited);
    waited = 0;
    @(negedge clk);
    while (s_req_ready == '0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // One full lookup; exp_g < 0 means the grant comes from the reference model.
  task automatic run_txn(input logic [NP-1:0] mask, input logic [31:0] base,
                         input int req_lat, input int rsp_lat, input int acc_lat,
                         input logic err, input logic [47:0] mac, input int exp_g);
    int g, waited;
    logic [NP-1:0] oh;
    g  = (exp_g >= 0) ? exp_g : model_pick(mask);
    oh = NP'(1) << g;
    set_ips(base);
    s_req_valid = mask;
    wait_grant(waited);
    chk("grant_onehot", 64'(s_req_ready), 64'(oh));
    chk("m_req_valid", 64'(m_arp_request_valid), 64'(1));
    chk("m_req_ip", 64'(m_arp_request_ip), 64'(base ^ 32'(g)));
    s_req_valid = '0;
    s_req_ip    = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (req_lat > 0) begin
      m_arp_response_valid = 1'b1;
      m_arp_response_mac   = ~mac;
    end
    for (int k = 0; k < req_lat; k++) begin
      @(negedge clk);
      chk("req_ready_pulse", 64'(s_req_ready), 64'(0));
      chk("req_hold_valid", 64'(m_arp_request_valid), 64'(1));
      chk("req_hold_ip", 64'(m_arp_request_ip), 64'(base ^ 32'(g)));
      chk("rsp_ready_in_req", 64'(m_arp_response_ready), 64'(0));
    end
    m_arp_response_valid = 1'b0;
    m_arp_request_ready  = 1'b1;
    @(negedge clk);
    m_arp_request_ready = 1'b0;
    chk("req_ready_pulse", 64'(s_req_ready), 64'(0));
    chk("req_valid_drop", 64'(m_arp_request_valid), 64'(0));
    chk("rsp_ready_wait", 64'(m_arp_response_ready), 64'(1));
    chk("busy_wait", 64'(busy), 64'(1));
    for (int k = 0; k < rsp_lat; k++) begin
      @(negedge clk);
      chk("no_resp_yet", 64'(s_resp_valid), 64'(0));
    end
    m_arp_response_valid = 1'b1;
    m_arp_response_error = err;
    m_arp_response_mac   = mac;
    @(negedge clk);
    m_arp_response_valid = 1'b0;
    m_arp_response_error = ~err;
    m_arp_response_mac   = 48'({$urandom(), $urandom()});
    chk("resp_valid", 64'(s_resp_valid), 64'(oh));
    chk("resp_mac", 64'(s_resp_mac), 64'(mac));
    chk("resp_err", 64'(s_resp_error), 64'(err));
    chk("rsp_ready_drop", 64'(m_arp_response_ready), 64'(0));
    s_resp_ready = ~oh;
    if (acc_lat > 0) s_req_valid = '1;
    for (int k = 0; k < acc_lat; k++) begin
      @(negedge clk);
      chk("resp_hold_valid", 64'(s_resp_valid), 64'(oh));
      chk("resp_hold_mac", 64'(s_resp_mac), 64'(mac));
      chk("resp_hold_err", 64'(s_resp_error), 64'(err));
      chk("no_grant_in_resp", 64'(s_req_ready), 64'(0));
    end
    s_resp_ready = oh;
    s_req_valid  = '0;
    @(negedge clk);
    s_resp_ready = '0;
    chk("resp_clear", 64'(s_resp_valid), 64'(0));
    chk("resp_mac_clear", 64'(s_resp_mac), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
    model_rr = (g + 1) % NP;
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    s_req_valid = '0; s_req_ip = '0; s_resp_ready = '0;
    m_arp_request_ready = 1'b0; m_arp_response_valid = 1'b0;
    m_arp_response_error = 1'b0; m_arp_response_mac = '0;

    //         mask     base           rq rs ac err mac                exp
    tbl[0]  = '{4'b1011, 32'hc0a80a00, 0, 0, 0, 1'b0, 48'h0200000000a0, 0};
    tbl[1]  = '{4'b1011, 32'hc0a80a10, 0, 0, 0, 1'b0, 48'h0200000000a1, 1};
    tbl[2]  = '{4'b1011, 32'hc0a80a20, 0, 0, 0, 1'b0, 48'h0200000000a3, 3};
    tbl[3]  = '{4'b1011, 32'hc0a80a30, 1, 0, 0, 1'b0, 48'h0200000000b0, 0};
    tbl[4]  = '{4'b1011, 32'hc0a80a40, 0, 1, 0, 1'b0, 48'h0200000000b1, 1};
    tbl[5]  = '{4'b1011, 32'hc0a80a50, 0, 0, 1, 1'b0, 48'h0200000000b3, 3};
    // Port p drives base ^ p, so port 2 presents c0a80164 here.
    tbl[6]  = '{4'b0100, 32'hc0a80166, 0, 0, 0, 1'b0, 48'h5a5152535455, 2};
    tbl[7]  = '{4'b0001, 32'h0a000001, 5, 2, 3, 1'b0, 48'h001122334455, 0};
    tbl[8]  = '{4'b0010, 32'hc0a80298, 0, 0, 0, 1'b1, 48'h000000000000, 1};
    tbl[9]  = '{4'b1111, 32'h0a0000f0, 0, 0, 0, 1'b0, 48'h665544332211, 2};
    tbl[10] = '{4'b1111, 32'h0a0000e0, 0, 0, 0, 1'b0, 48'h0a0b0c0d0e0f, 3};
    tbl[11] = '{4'b0101, 32'h0a0000d0, 0, 0, 0, 1'b0, 48'hfedcba987654, 0};
    tbl[12] = '{4'b0101, 32'h0a0000c0, 0, 0, 0, 1'b0, 48'h123456789abc, 2};

    repeat (2) @(negedge clk);
    check_reset("rst_init");
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      run_txn(tbl[i].mask, tbl[i].base, tbl[i].req_lat, tbl[i].rsp_lat,
              tbl[i].acc_lat, tbl[i].err, tbl[i].mac, tbl[i].exp_g);

    for (int i = 0; i < 30; i++)
      run_txn(NP'($urandom_range(1, 15)), $urandom(), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom()),
              48'({$urandom(), $urandom()}), -1);

    // Reset while waiting on the ARP response.
    set_ips(32'hc0a80300);
    s_req_valid = 4'b0100;
    wait_grant(waited);
    chk("rw_grant", 64'(s_req_ready), 64'(4'b0100));
    s_req_valid = '0;
    m_arp_request_ready = 1'b1;
    @(negedge clk);
    m_arp_request_ready = 1'b0;
    chk("rw_busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1 check_reset("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
    run_txn(4'b1111, 32'hc0a80400, 0, 0, 0, 1'b0, 48'h0a1b2c3d4e5f, 0);

`ifdef ARP_REQ_TIMEOUT_EN
    // Watchdog: no response for 40 cycles, then a late one that must be swallowed.
    set_ips(32'hc0a80500);
    s_req_valid = 4'b0010;
    wait_grant(waited);
    chk("to_grant", 64'(s_req_ready), 64'(4'b0010));
    s_req_valid = '0;
    m_arp_request_ready = 1'b1;
    @(negedge clk);
    m_arp_request_ready = 1'b0;
    waited = 0;
    while (s_resp_valid == '0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("to_cycles", 64'(waited), 64'(16));
    chk("to_resp_valid", 64'(s_resp_valid), 64'(4'b0010));
    chk("to_resp_err", 64'(s_resp_error), 64'(1));
    chk("to_resp_mac", 64'(s_resp_mac), 64'(0));
    s_resp_ready = 4'b0010;
    @(negedge clk);
    s_resp_ready = '0;
    model_rr = 2;
    chk("to_stale_ready", 64'(m_arp_response_ready), 64'(1));
    chk("to_busy", 64'(busy), 64'(0));
    repeat (22) @(negedge clk);
    m_arp_response_valid = 1'b1;
    m_arp_response_mac   = 48'hdeadbeef0001;
    @(negedge clk);
    m_arp_response_valid = 1'b0;
    chk("to_late_dropped", 64'(s_resp_valid), 64'(0));
    chk("to_stale_clear", 64'(m_arp_response_ready), 64'(0));
    run_txn(4'b0100, 32'hc0a80600, 0, 0, 0, 1'b0, 48'h5a5152535499, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
